input_debouncer: RTL and testbench

Multi-channel switch/button conditioning stage that sits directly upstream of the combinational gate blocks. It feeds their `i0`/`i1` inputs from board switches. Each raw input is passed through a two-flop synchronizer, then a per-channel debounce counter. Only a level held stable for `STABLE_CYCLES` consecutive clocks reaches the output, so downstream gates see clean, glitch-free levels.

---
 rtl/input_debouncer.sv | 122 ++++++++++++
 tb/tb_input_debouncer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Multi-channel switch conditioner: two-flop synchronizer plus per-channel debounce FSM.
// Optional macro DEBOUNCE_EDGE_EN compiles in the rise/fall edge pulse logic.
module input_debouncer #(
    parameter int WIDTH         = 2,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Bit 1 of the encoding is the debounced level, so o comes straight off a flop.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two-flop synchronizer; sync2 is the only view of raw used below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    genvar n;
    for (n = 0; n < WIDTH; n++) begin : g_ch
        state_t           state;
        state_t           state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;

        // Per-channel state and stability counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= STABLE_LO;
                cnt   <= '0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        // Next state: enter WAIT on a change, commit after STABLE_CYCLES, drop on bounce.
        always_comb begin
            state_next = state;
            cnt_next   = '0;
            unique case (state)
                STABLE_LO: begin
                    if (sync2[n]) begin
                        state_next = WAIT_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!sync2[n]) begin
                        state_next = STABLE_LO;
                    end else if (cnt == STABLE_CNT) begin
                        state_next = STABLE_HI;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync2[n]) begin
                        state_next = WAIT_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (sync2[n]) begin
                        state_next = STABLE_HI;
                    end else if (cnt == STABLE_CNT) begin
                        state_next = STABLE_LO;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_next = STABLE_LO;
                end
            endcase
        end

        assign o[n] = state[1];
    end

`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] o_d;

    // One-cycle delayed copy of o for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_d <= '0;
        end else begin
            o_d <= o;
        end
    end

    assign rise = o & ~o_d;
    assign fall = ~o & o_d;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with WIDTH=2, CNT_W=4, STABLE_CYCLES=4.
// Edge-pulse expectations follow DEBOUNCE_EDGE_EN; with it undefined they are always 0.
module tb_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] o;
    logic [1:0] rise;
    logic [1:0] fall;

    int n_tests;
    int n_fail;

    input_debouncer #(
        .WIDTH        (2),
        .CNT_W        (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw),
        .o    (o),
        .rise (rise),
        .fall (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ep(input logic [1:0] v);
`ifdef DEBOUNCE_EDGE_EN
        return v;
`else
        return 2'b00;
`endif
    endfunction

    // Hold current raw for 7 edges: o steady for 6, new level on the 7th.
    task automatic settle(input string tag, input logic [1:0] o_old,
                          input logic [1:0] o_new, input logic [1:0] r_exp,
                          input logic [1:0] f_exp);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk({tag, "_hold_o"}, o, o_old);
        end
        tick();
        chk({tag, "_o"}, o, o_new);
        chk({tag, "_rise"}, rise, ep(r_exp));
        chk({tag, "_fall"}, fall, ep(f_exp));
        tick();
        chk({tag, "_o_next"}, o, o_new);
        chk({tag, "_rise_next"}, rise, 2'b00);
        chk({tag, "_fall_next"}, fall, 2'b00);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        raw     = 2'b11;

        // Reset held with raw high
        repeat (3) tick();
        chk("rst_o", o, 2'b00);
        chk("rst_rise", rise, 2'b00);
        chk("rst_fall", fall, 2'b00);
        rst_n = 1'b1;
        settle("rel", 2'b00, 2'b11, 2'b11, 2'b00);

        // Return to 00
        raw = 2'b00;
        settle("clr", 2'b11, 2'b00, 2'b00, 2'b11);

        // Clean press on channel 0
        raw = 2'b01;
        settle("press", 2'b00, 2'b01, 2'b01, 2'b00);

        // Back low, then bounce 1,0,1,0 with 3-cycle widths
        raw = 2'b00;
        settle("unpress", 2'b01, 2'b00, 2'b00, 2'b01);
        for (int p = 0; p < 4; p++) begin
            raw = (p % 2 == 0) ? 2'b01 : 2'b00;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("bounce_o", o, 2'b00);
                chk("bounce_rise", rise, 2'b00);
            end
        end
        raw = 2'b01;
        settle("bsettle", 2'b00, 2'b01, 2'b01, 2'b00);

        // Release channel 1 only, channel 0 held
        raw = 2'b11;
        settle("up1", 2'b01, 2'b11, 2'b10, 2'b00);
        raw = 2'b01;
        settle("drop1", 2'b11, 2'b01, 2'b00, 2'b10);

        // Mid-WAIT reset
        raw = 2'b00;
        settle("clr2", 2'b01, 2'b00, 2'b00, 2'b01);
        raw = 2'b01;
        repeat (4) tick();
        chk("mid_pre_o", o, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o", o, 2'b00);
        repeat (5) tick();
        chk("mid_hold_o", o, 2'b00);
        chk("mid_hold_rise", rise, 2'b00);
        rst_n = 1'b1;
        settle("mid_rel", 2'b00, 2'b01, 2'b01, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
